// File: rtl/mux_rr_arbiter.sv
// Round-robin grant/select controller for the 8:1 mux; grant one cycle after request, held until done, req drop or MAX_HOLD.
// No backpressure: each grant ends with a RELEASE cycle and an IDLE cycle before the next grant.
module mux_rr_arbiter #(
  parameter int N        = 8,
  parameter int SELW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] sel,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [N-1:0] ONE     = N'(1);
  localparam logic [7:0]   HOLDMAX = 8'(MAX_HOLD);

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [7:0]      cnt;
  logic [SELW-1:0] win;
  logic [SELW-1:0] idx;
  logic            release_now;

  // Scan from the highest offset down so the requester closest to ptr wins last.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr + SELW'(i);
      if (req[idx]) win = idx;
    end
  end

  assign release_now = done || !req[sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= ONE << win;
            sel       <= win;
            gnt_valid <= 1'b1;
            cnt       <= 8'd1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (release_now || cnt == HOLDMAX) begin
            // done wins over expiry, so timeout flags only a genuine revocation.
            timeout   <= !release_now;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= sel + SELW'(1);
            cnt       <= '0;
            state     <= RELEASE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter against a behavioural model of the grant rules.
module tb_mux_rr_arbiter;
  localparam int N = 8;
  localparam int SELW = 3;
  localparam int MAX_HOLD = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic            done = 1'b0;
  logic [N-1:0]    gnt;
  logic [SELW-1:0] sel;
  logic            gnt_valid;
  logic            timeout;

  int checks = 0;
  int errors = 0;

  // model state: phase 0 = idle, 1 = owned, 2 = release bubble
  int m_phase, m_owner, m_ptr, m_held, m_to;

  mux_rr_arbiter #(.N(N), .SELW(SELW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic d);
    m_to = 0;
    if (m_phase == 0) begin
      if (r != 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_phase = 1;
        m_held = 1;
      end
    end else if (m_phase == 1) begin
      if (d || !r[m_owner]) begin
        m_phase = 2; m_ptr = (m_owner + 1) % N;
      end else if (m_held == MAX_HOLD) begin
        m_phase = 2; m_ptr = (m_owner + 1) % N; m_to = 1;
      end else begin
        m_held++;
      end
    end else begin
      m_phase = 0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg;
    eg = (m_phase == 1) ? N'(1) << m_owner : '0;
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".sel"}, 32'(sel), 32'(m_owner));
    chk({tag, ".vld"}, 32'(gnt_valid), 32'(m_phase == 1));
    chk({tag, ".to"},  32'(timeout), 32'(m_to));
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic d, input string tag);
    req = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    done = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] r;
    int hold_cycles;
    model_reset();
    #2;
    check_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // single request, then done
    cycle(8'b0000_0100, 1'b0, "single");
    chk("single.sel", 32'(sel), 32'd2);
    cycle(8'b0000_0100, 1'b1, "single_rel");
    chk("single.ptr", 32'(m_ptr), 32'd3);

    // fairness with all requesters active
    do_reset();
    for (int g = 0; g < 9; g++) begin
      cycle(8'hFF, 1'b0, "fair_gnt");
      chk("fair.seq", 32'(sel), 32'(g % N));
      cycle(8'hFF, 1'b1, "fair_rel");
      chk("fair.bubble", 32'(gnt_valid), 32'd0);
      cycle(8'hFF, 1'b0, "fair_idle");
    end

    // wrap-around from 7 back to 0
    do_reset();
    cycle(8'h80, 1'b0, "wrap_g7");
    cycle(8'h81, 1'b1, "wrap_rel");
    cycle(8'h81, 1'b0, "wrap_idle");
    cycle(8'h81, 1'b0, "wrap_g0");
    chk("wrap.sel", 32'(sel), 32'd0);

    // hold timeout
    do_reset();
    cycle(8'h20, 1'b0, "to_gnt");
    hold_cycles = 1;
    for (int k = 1; k < MAX_HOLD; k++) begin
      cycle(8'h20, 1'b0, "to_hold");
      if (gnt_valid) hold_cycles++;
    end
    cycle(8'h20, 1'b0, "to_exp");
    chk("to.held", 32'(hold_cycles), 32'(MAX_HOLD));
    chk("to.pulse", 32'(timeout), 32'd1);
    cycle(8'h20, 1'b0, "to_idle");
    chk("to.oneshot", 32'(timeout), 32'd0);
    cycle(8'h20, 1'b0, "to_regnt");
    chk("to.resel", 32'(sel), 32'd5);

    // done on the expiry edge is a normal release
    for (int k = 1; k < MAX_HOLD; k++) cycle(8'h20, 1'b0, "sim_hold");
    cycle(8'h20, 1'b1, "sim_done");
    chk("sim.noto", 32'(timeout), 32'd0);
    cycle(8'h20, 1'b0, "sim_idle");
    cycle(8'h20, 1'b0, "sim_gnt");
    cycle(8'h08, 1'b0, "swap_rel");
    chk("swap.bubble", 32'(gnt_valid), 32'd0);
    cycle(8'h08, 1'b0, "swap_idle");
    cycle(8'h08, 1'b0, "swap_gnt");
    chk("swap.sel", 32'(sel), 32'd3);

    // async reset between edges while granted
    do_reset();
    cycle(8'h40, 1'b0, "ar_gnt");
    chk("ar.gnt", 32'(gnt), 32'h40);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("ar_async");
    #1;
    rst = 1'b0;
    cycle(8'hC0, 1'b0, "ar_post");
    chk("ar.first", 32'(sel), 32'd6);

    // random traffic
    do_reset();
    r = '0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      if ($urandom_range(0, 5) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
      cycle(r, (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : 1'b0, "rand");
      chk("rand.inv", 32'(gnt_valid), 32'(|gnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
